pipe_hazard_ctrl: RTL and testbench

- Pipelined control and hazard unit for the 5-stage MIPS core; successor of the single-decode control unit.
- Decodes the D-stage instruction and carries per-stage destination and Tnew tags through the E, M and W stages.
- Generates the stall/bubble and forwarding selects.
- Adds a busy counter for a mult/div unit with parametrised latency.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 73 +++++++
 rtl/pipe_hazard_ctrl_instr_class_dec.sv | 113 +++++++++++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared decode constants, instruction classes and pipeline tag helpers
// for the pipelined hazard/control unit.
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] FWD_GRF  = 2'd0;
    localparam logic [1:0] FWD_PIPE = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_E    = 2'd3;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;
    localparam logic [1:0] TNEW_JAL    = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CALC_R, CLS_CALC_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JUMP, CLS_JUMP_REG, CLS_JAL, CLS_MD, CLS_MF, CLS_MT
    } instr_class_t;

    // rs/rt are carried zeroed when the instruction does not read them,
    // so an unused source can never match a destination downstream.
    typedef struct packed {
        logic [4:0] a3;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tnew;
        logic       is_md;
        logic       is_div;
        logic       is_load;
    } stage_tag_t;

    function automatic stage_tag_t age_tag(input stage_tag_t t);
        stage_tag_t r;
        r = t;
        if (t.tnew != 2'd0) r.tnew = t.tnew - 2'd1;
        return r;
    endfunction

    function automatic logic fwd_hit(input logic [4:0] r, input stage_tag_t t);
        return (r != 5'd0) && (r == t.a3) && (t.tnew == 2'd0);
    endfunction

    function automatic logic data_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                         input stage_tag_t t);
        return (r != 5'd0) && (r == t.a3) && (t.tnew > tuse);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_instr_class_dec.sv
// Combinational D-stage decoder: instruction class, source usage with
// their Tuse, result Tnew and destination register.
import pipe_hazard_ctrl_pkg::*;

module instr_class_dec (
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic         rs_use,
    output logic         rt_use,
    output logic [1:0]   tuse_rs,
    output logic [1:0]   tuse_rt,
    output logic [1:0]   tnew,
    output logic [4:0]   a3,
    output logic         is_md,
    output logic         is_div,
    output logic         is_load
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    // Classify the instruction; anything outside the supported set stays a nop
    always_comb begin
        cls     = CLS_NOP;
        rs_use  = 1'b0;
        rt_use  = 1'b0;
        tuse_rs = TUSE_ALU;
        tuse_rt = TUSE_ALU;
        tnew    = 2'd0;
        a3      = 5'd0;
        is_md   = 1'b0;
        is_div  = 1'b0;
        is_load = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_SLT: begin
                        cls    = CLS_CALC_R;
                        rs_use = 1'b1;
                        rt_use = 1'b1;
                        tnew   = TNEW_ALU;
                        a3     = instr[15:11];
                    end
                    FN_JR: begin
                        cls     = CLS_JUMP_REG;
                        rs_use  = 1'b1;
                        tuse_rs = TUSE_BRANCH;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        cls    = CLS_MD;
                        rs_use = 1'b1;
                        rt_use = 1'b1;
                        is_md  = 1'b1;
                        is_div = (funct == FN_DIV) || (funct == FN_DIVU);
                    end
                    FN_MFHI, FN_MFLO: begin
                        cls  = CLS_MF;
                        tnew = TNEW_ALU;
                        a3   = instr[15:11];
                    end
                    FN_MTHI, FN_MTLO: begin
                        cls    = CLS_MT;
                        rs_use = 1'b1;
                    end
                    default: cls = CLS_NOP;
                endcase
            end
            OP_ORI: begin
                cls    = CLS_CALC_I;
                rs_use = 1'b1;
                tnew   = TNEW_ALU;
                a3     = instr[20:16];
            end
            OP_LUI: begin
                cls  = CLS_CALC_I;
                tnew = TNEW_ALU;
                a3   = instr[20:16];
            end
            OP_LW: begin
                cls     = CLS_LOAD;
                rs_use  = 1'b1;
                tnew    = TNEW_LOAD;
                a3      = instr[20:16];
                is_load = 1'b1;
            end
            OP_SW: begin
                cls     = CLS_STORE;
                rs_use  = 1'b1;
                rt_use  = 1'b1;
                tuse_rt = TUSE_STORE;
            end
            OP_BEQ: begin
                cls     = CLS_BRANCH;
                rs_use  = 1'b1;
                rt_use  = 1'b1;
                tuse_rs = TUSE_BRANCH;
                tuse_rt = TUSE_BRANCH;
            end
            OP_J:   cls = CLS_JUMP;
            OP_JAL: begin
                cls  = CLS_JAL;
                tnew = TNEW_JAL;
                a3   = 5'd31;
            end
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipelined hazard/control unit: per-stage destination tags, stall and
// bubble generation, forwarding selects and the mult/div busy counter.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m,
    output logic [4:0]  a3_e,
    output logic [4:0]  a3_m,
    output logic [4:0]  a3_w,
    output logic        grf_we_w,
    output logic        md_start_e,
    output logic        md_busy
);
    instr_class_t     cls_d;
    logic             rs_use_d, rt_use_d;
    logic [1:0]       tuse_rs_d, tuse_rt_d, tnew_d;
    logic [4:0]       a3_d;
    logic             is_md_d, is_div_d, is_load_d;
    stage_tag_t       tag_dec, tag_e, tag_m, tag_w;
    logic [CNT_W-1:0] cnt;
    logic             data_stall, md_stall, md_class_d;
    logic             unused_tag_bits;

    instr_class_dec u_dec (
        .instr   (instr_d),
        .cls     (cls_d),
        .rs_use  (rs_use_d),
        .rt_use  (rt_use_d),
        .tuse_rs (tuse_rs_d),
        .tuse_rt (tuse_rt_d),
        .tnew    (tnew_d),
        .a3      (a3_d),
        .is_md   (is_md_d),
        .is_div  (is_div_d),
        .is_load (is_load_d)
    );

    assign unused_tag_bits = ^{tag_e.is_load, tag_m.rs, tag_m.is_md, tag_m.is_div,
                               tag_m.is_load, tag_w.rs, tag_w.rt, tag_w.is_md,
                               tag_w.is_div, tag_w.is_load};

    // Assemble the tag the D instruction would carry into E
    always_comb begin
        tag_dec         = '0;
        tag_dec.a3      = a3_d;
        tag_dec.rs      = rs_use_d ? instr_d[25:21] : 5'd0;
        tag_dec.rt      = rt_use_d ? instr_d[20:16] : 5'd0;
        tag_dec.tnew    = tnew_d;
        tag_dec.is_md   = is_md_d;
        tag_dec.is_div  = is_div_d;
        tag_dec.is_load = is_load_d;
    end

    // Advance tags down the pipe; a stalled D becomes a bubble in E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_e <= '0;
            tag_m <= '0;
            tag_w <= '0;
        end else begin
            tag_e <= stall ? '0 : tag_dec;
            tag_m <= age_tag(tag_e);
            tag_w <= age_tag(tag_m);
        end
    end

    // MD busy counter: load latency when an MD op sits in E, else count down
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (md_start_e) begin
            cnt <= tag_e.is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign md_start_e = tag_e.is_md;
    assign md_busy    = (cnt != '0);

    // Stall when a D source is produced too late, or HI/LO is still in use
    always_comb begin
        data_stall = data_hazard(tag_dec.rs, tuse_rs_d, tag_e) ||
                     data_hazard(tag_dec.rs, tuse_rs_d, tag_m) ||
                     data_hazard(tag_dec.rt, tuse_rt_d, tag_e) ||
                     data_hazard(tag_dec.rt, tuse_rt_d, tag_m);
        md_class_d = (cls_d == CLS_MD) || (cls_d == CLS_MF) || (cls_d == CLS_MT);
        md_stall   = md_class_d && (md_busy || md_start_e);
        stall      = data_stall || md_stall;
    end

    // Forward selects, youngest producer with a ready result wins
    always_comb begin
        fwd_rs_d = FWD_GRF;
        fwd_rt_d = FWD_GRF;
        fwd_rs_e = FWD_PIPE;
        fwd_rt_e = FWD_PIPE;
        fwd_rt_m = 1'b0;
        if      (fwd_hit(tag_dec.rs, tag_e)) fwd_rs_d = FWD_E;
        else if (fwd_hit(tag_dec.rs, tag_m)) fwd_rs_d = FWD_M;
        else if (fwd_hit(tag_dec.rs, tag_w)) fwd_rs_d = FWD_W;
        if      (fwd_hit(tag_dec.rt, tag_e)) fwd_rt_d = FWD_E;
        else if (fwd_hit(tag_dec.rt, tag_m)) fwd_rt_d = FWD_M;
        else if (fwd_hit(tag_dec.rt, tag_w)) fwd_rt_d = FWD_W;
        if      (fwd_hit(tag_e.rs, tag_m))   fwd_rs_e = FWD_M;
        else if (fwd_hit(tag_e.rs, tag_w))   fwd_rs_e = FWD_W;
        if      (fwd_hit(tag_e.rt, tag_m))   fwd_rt_e = FWD_M;
        else if (fwd_hit(tag_e.rt, tag_w))   fwd_rt_e = FWD_W;
        fwd_rt_m = fwd_hit(tag_m.rt, tag_w);
    end

    assign a3_e     = tag_e.a3;
    assign a3_m     = tag_m.a3;
    assign a3_w     = tag_w.a3;
    assign grf_we_w = (tag_w.a3 != 5'd0);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch, jal/jr, mult/div
// busy timing, $0 destination, store-data forwarding and async reset.
module tb_pipe_hazard_ctrl;
    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic        fwd_rt_m;
    logic [4:0]  a3_e, a3_m, a3_w;
    logic        grf_we_w, md_start_e, md_busy;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_d    (instr_d),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .fwd_rt_m   (fwd_rt_m),
        .a3_e       (a3_e),
        .a3_m       (a3_m),
        .a3_w       (a3_w),
        .grf_we_w   (grf_we_w),
        .md_start_e (md_start_e),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // MD start while the counter still runs must never be observed
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (md_start_e && md_busy) $display("[TB] FAIL md_overlap: start=%0b busy=%0b want not both", md_start_e, md_busy);
            else n_pass++;
        end
    end

    // Put instr in D for the cycle that starts at the next rising edge
    task automatic step_instr(input logic [31:0] instr);
        @(posedge clk);
        #1 instr_d = instr;
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step_instr(32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_d = 32'h0;
        #2;
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL rst_stall: got %0b want 0", stall); else n_pass++;
        n_checks++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0) $display("[TB] FAIL rst_fwd: got %0h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}); else n_pass++;
        n_checks++; if ({a3_e, a3_m, a3_w, grf_we_w, md_start_e, md_busy} !== 18'd0) $display("[TB] FAIL rst_tags: got %0h want 0", {a3_e, a3_m, a3_w, grf_we_w, md_start_e, md_busy}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        flush();
        step_instr(itype(6'h23, 5'd0, 5'd1, 16'h0));
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL lu_lw_d_stall: got %0b want 0", stall); else n_pass++;
        step_instr(rtype(5'd1, 5'd3, 5'd2, 6'h21));
        n_checks++; if (stall !== 1'b1) $display("[TB] FAIL lu_stall: got %0b want 1", stall); else n_pass++;
        n_checks++; if (a3_e !== 5'd1) $display("[TB] FAIL lu_a3_e: got %0d want 1", a3_e); else n_pass++;
        step_instr(rtype(5'd1, 5'd3, 5'd2, 6'h21));
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL lu_release: got %0b want 0", stall); else n_pass++;
        n_checks++; if (a3_e !== 5'd0 || a3_m !== 5'd1) $display("[TB] FAIL lu_bubble: got a3_e=%0d a3_m=%0d want 0/1", a3_e, a3_m); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (fwd_rs_e !== 2'd1) $display("[TB] FAIL lu_fwd_rs_e: got %0d want 1", fwd_rs_e); else n_pass++;
        n_checks++; if (fwd_rt_e !== 2'd0) $display("[TB] FAIL lu_fwd_rt_e: got %0d want 0", fwd_rt_e); else n_pass++;
        n_checks++; if (a3_w !== 5'd1 || grf_we_w !== 1'b1) $display("[TB] FAIL lu_w: got a3_w=%0d we=%0b want 1/1", a3_w, grf_we_w); else n_pass++;
    endtask

    task automatic test_branch();
        flush();
        step_instr(itype(6'h0d, 5'd0, 5'd4, 16'd5));
        step_instr(itype(6'h04, 5'd4, 5'd4, 16'd3));
        n_checks++; if (stall !== 1'b1) $display("[TB] FAIL br_stall: got %0b want 1", stall); else n_pass++;
        step_instr(itype(6'h04, 5'd4, 5'd4, 16'd3));
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL br_release: got %0b want 0", stall); else n_pass++;
        n_checks++; if (fwd_rs_d !== 2'd2 || fwd_rt_d !== 2'd2) $display("[TB] FAIL br_fwd_d: got rs=%0d rt=%0d want 2/2", fwd_rs_d, fwd_rt_d); else n_pass++;
    endtask

    task automatic test_jal_jr();
        flush();
        step_instr({6'b000011, 26'h10});
        step_instr(rtype(5'd31, 5'd0, 5'd0, 6'h08));
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL jr_stall: got %0b want 0", stall); else n_pass++;
        n_checks++; if (fwd_rs_d !== 2'd3) $display("[TB] FAIL jr_fwd_rs_d: got %0d want 3", fwd_rs_d); else n_pass++;
        n_checks++; if (a3_e !== 5'd31) $display("[TB] FAIL jr_a3_e: got %0d want 31", a3_e); else n_pass++;
    endtask

    task automatic test_md(input logic [5:0] fn, input int exp_stalls, input int exp_busy);
        int stalls;
        int busy;
        flush();
        step_instr(rtype(5'd5, 5'd6, 5'd0, fn));
        step_instr(rtype(5'd0, 5'd0, 5'd7, 6'h12));
        n_checks++; if (md_start_e !== 1'b1 || md_busy !== 1'b0) $display("[TB] FAIL md_start_%0h: got start=%0b busy=%0b want 1/0", fn, md_start_e, md_busy); else n_pass++;
        stalls = 0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall) stalls++;
            if (md_busy) busy++;
            if (!stall) break;
            step_instr(rtype(5'd0, 5'd0, 5'd7, 6'h12));
        end
        n_checks++; if (stalls != exp_stalls) $display("[TB] FAIL md_stalls_%0h: got %0d want %0d", fn, stalls, exp_stalls); else n_pass++;
        n_checks++; if (busy != exp_busy) $display("[TB] FAIL md_busy_%0h: got %0d want %0d", fn, busy, exp_busy); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (a3_e !== 5'd7) $display("[TB] FAIL md_mflo_e_%0h: got %0d want 7", fn, a3_e); else n_pass++;
    endtask

    task automatic test_zero_dest();
        flush();
        step_instr(rtype(5'd1, 5'd2, 5'd0, 6'h21));
        step_instr(rtype(5'd0, 5'd0, 5'd6, 6'h21));
        n_checks++; if (stall !== 1'b0 || a3_e !== 5'd0) $display("[TB] FAIL z_stall: got stall=%0b a3_e=%0d want 0/0", stall, a3_e); else n_pass++;
        n_checks++; if ({fwd_rs_d, fwd_rt_d} !== 4'd0) $display("[TB] FAIL z_fwd_d: got %0h want 0", {fwd_rs_d, fwd_rt_d}); else n_pass++;
        step_instr(32'h0);
        n_checks++; if ({fwd_rs_e, fwd_rt_e} !== 4'd0) $display("[TB] FAIL z_fwd_e: got %0h want 0", {fwd_rs_e, fwd_rt_e}); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (grf_we_w !== 1'b0 || a3_w !== 5'd0) $display("[TB] FAIL z_we_w: got we=%0b a3_w=%0d want 0/0", grf_we_w, a3_w); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (grf_we_w !== 1'b1 || a3_w !== 5'd6) $display("[TB] FAIL z_reader_w: got we=%0b a3_w=%0d want 1/6", grf_we_w, a3_w); else n_pass++;
    endtask

    task automatic test_store_data();
        flush();
        step_instr(itype(6'h23, 5'd0, 5'd8, 16'h0));
        step_instr(itype(6'h2b, 5'd0, 5'd8, 16'h4));
        n_checks++; if (stall !== 1'b0) $display("[TB] FAIL sw_stall: got %0b want 0", stall); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (fwd_rt_e !== 2'd0) $display("[TB] FAIL sw_fwd_rt_e: got %0d want 0", fwd_rt_e); else n_pass++;
        step_instr(32'h0);
        n_checks++; if (fwd_rt_m !== 1'b1) $display("[TB] FAIL sw_fwd_rt_m: got %0b want 1", fwd_rt_m); else n_pass++;
    endtask

    task automatic test_reset_mid();
        flush();
        step_instr(rtype(5'd5, 5'd6, 5'd0, 6'h1a));
        step_instr(32'h0);
        step_instr(32'h0);
        step_instr(32'h0);
        step_instr(itype(6'h23, 5'd0, 5'd9, 16'h0));
        step_instr(rtype(5'd0, 5'd0, 5'd7, 6'h12));
        n_checks++; if (stall !== 1'b1 || md_busy !== 1'b1 || a3_e !== 5'd9) $display("[TB] FAIL rm_pre: got stall=%0b busy=%0b a3_e=%0d want 1/1/9", stall, md_busy, a3_e); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (md_busy !== 1'b0 || a3_e !== 5'd0 || stall !== 1'b0) $display("[TB] FAIL rm_async: got busy=%0b a3_e=%0d stall=%0b want 0/0/0", md_busy, a3_e, stall); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        instr_d = 32'h0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_md(6'h18, 6, 5);
        test_md(6'h1a, 11, 10);
        test_zero_dest();
        test_store_data();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
